// File: rtl/multdiv_pkg.sv
// multdiv_pkg
// Shared definitions for the sequential multiply/divide unit.
//   state_e        : controller states (IDLE, MULT, DIV, DONE)
//   WIDTH_DEFAULT  : default operand/result width
//   INT_MIN        : most negative 32-bit value, the divide-overflow dividend
package multdiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/multdiv_seq_if.sv
// multdiv_seq_if
// Start/operand/result bundle between the execute stage and the
// multiply/divide unit.
//   ctrl_MULT, ctrl_DIV            : one-cycle start pulses (master -> slave)
//   data_operandA, data_operandB   : operands, sampled on a start pulse
//   data_result, data_hi           : low word / quotient, high product word
//   data_exception, data_resultRDY : overflow or div-by-zero, ready pulse
//   busy                           : operation in flight
interface multdiv_seq_if #(
  parameter int WIDTH = 32
);

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_hi;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_hi, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_hi, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/multdiv_seq_and32.sv
// multdiv_seq_and32
// 32-input AND reduction used for the all-ones / all-zeros detect on the
// product high word.
//   data_i : 32-bit vector to reduce
//   all_o  : 1 when every bit of data_i is 1
module multdiv_seq_and32 (
  input  logic [31:0] data_i,
  output logic        all_o
);

  assign all_o = &data_i;

endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit,
// one bit per cycle. A start pulse in any state restarts the unit; results
// are registered when the last iteration finishes and held until the next
// start or reset. data_resultRDY pulses for the single DONE cycle.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : multdiv_seq_if slave port (start pulses, operands, results)
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6
) (
  input logic          clock,
  input logic          reset_n,
  multdiv_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Booth register {hi, lo, q-1}; the multiplicand is kept separately.
  logic [2*WIDTH:0]   booth_q, booth_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;

  // Restoring divider: partial remainder, quotient/dividend shift register,
  // divisor magnitude, sign of the final quotient and the INT_MIN/-1 flag.
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               negQ_q, negQ_d;
  logic               divOvf_q, divOvf_d;

  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               exc_q, exc_d;

  logic               startReq;
  logic [WIDTH-1:0]   absA, absB;

  logic [WIDTH:0]     boothHiExt, mcandExt, boothSum;
  logic [2*WIDTH:0]   boothStep;
  logic [WIDTH-1:0]   prodHi, prodHiN, prodLo;
  logic               hiAllOnes, hiAllZeros, mulOvf;

  logic [WIDTH:0]     divShifted, divTrial;
  logic [WIDTH-1:0]   remNext, quotNext, quotSigned;

  assign startReq = bus.ctrl_MULT | bus.ctrl_DIV;

  assign absA = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
  assign absB = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;

  // Booth step. The add/sub is done one bit wider than hi: with a multiplicand
  // of INT_MIN the intermediate sum can reach +2^31, which only becomes
  // representable in WIDTH bits again after the arithmetic shift.
  always_comb begin
    boothHiExt = {booth_q[2*WIDTH], booth_q[2*WIDTH:WIDTH+1]};
    mcandExt   = {mcand_q[WIDTH-1], mcand_q};
    unique case (booth_q[1:0])
      2'b01:   boothSum = boothHiExt + mcandExt;
      2'b10:   boothSum = boothHiExt - mcandExt;
      default: boothSum = boothHiExt;
    endcase
    // Shifted result: the wide sum supplies the new hi and the top lo bit,
    // the old lo supplies the rest of lo and the new q-1.
    boothStep = {boothSum, booth_q[WIDTH:1]};
  end

  assign prodHi  = boothStep[2*WIDTH:WIDTH+1];
  assign prodLo  = boothStep[WIDTH:1];
  assign prodHiN = ~prodHi;

  multdiv_seq_and32 u_andHi (
    .data_i (prodHi),
    .all_o  (hiAllOnes)
  );

  multdiv_seq_and32 u_andHiN (
    .data_i (prodHiN),
    .all_o  (hiAllZeros)
  );

  // Product fits in WIDTH bits only when hi is a pure sign extension of lo.
  assign mulOvf = ~((hiAllOnes & prodLo[WIDTH-1]) | (hiAllZeros & ~prodLo[WIDTH-1]));

  // Restoring divide step on magnitudes.
  always_comb begin
    divShifted = {rem_q, quot_q[WIDTH-1]};
    divTrial   = divShifted - {1'b0, divisor_q};
    if (!divTrial[WIDTH]) begin
      remNext  = divTrial[WIDTH-1:0];
      quotNext = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      remNext  = divShifted[WIDTH-1:0];
      quotNext = {quot_q[WIDTH-2:0], 1'b0};
    end
    quotSigned = negQ_q ? (~quotNext + 1'b1) : quotNext;
  end

  // Controller and datapath next state. A start pulse overrides whatever the
  // unit is doing; result registers only change when an operation completes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    booth_d   = booth_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    negQ_d    = negQ_q;
    divOvf_d  = divOvf_q;
    result_d  = result_q;
    hi_d      = hi_q;
    exc_d     = exc_q;

    if (startReq) begin
      cnt_d     = '0;
      mcand_d   = bus.data_operandA;
      booth_d   = {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
      rem_d     = '0;
      quot_d    = absA;
      divisor_d = absB;
      negQ_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      divOvf_d  = (bus.data_operandA == INT_MIN[WIDTH-1:0]) && (bus.data_operandB == '1);
      if (bus.ctrl_MULT) begin
        state_d = MULT;
      end else if (bus.data_operandB == '0) begin
        // Divide-by-zero skips the iterations entirely.
        state_d  = DONE;
        result_d = '0;
        hi_d     = '0;
        exc_d    = 1'b1;
      end else begin
        state_d = DIV;
      end
    end else begin
      unique case (state_q)
        MULT: begin
          booth_d = boothStep;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d  = DONE;
            result_d = prodLo;
            hi_d     = prodHi;
            exc_d    = mulOvf;
          end
        end
        DIV: begin
          rem_d  = remNext;
          quot_d = quotNext;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d  = DONE;
            result_d = quotSigned;
            hi_d     = '0;
            exc_d    = divOvf_q;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      booth_q   <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      negQ_q    <= 1'b0;
      divOvf_q  <= 1'b0;
      result_q  <= '0;
      hi_q      <= '0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      booth_q   <= booth_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      negQ_q    <= negQ_d;
      divOvf_q  <= divOvf_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      exc_q     <= exc_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_hi        = hi_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.busy           = (state_q == MULT) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq
// Self-checking bench for multdiv_seq: directed cases with literal
// expectations plus randomized operations, all compared every cycle against
// an arithmetic reference model with a latency countdown.
module tb_multdiv_seq;
  import multdiv_pkg::*;

  logic clock = 1'b0;
  logic reset_n;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  multdiv_seq_if #(.WIDTH(32)) bus ();

  multdiv_seq #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Reference model state: visible outputs and the pending operation.
  logic [31:0] eResult, eHi, pResult, pHi;
  logic        eExc, pExc, eRdy, eBusy;
  int          left, lat;
  int          mA, mB;
  longint      mP;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compute each operation's result with plain signed arithmetic when
  // it starts, then release it to the outputs after its latency.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eResult = '0; eHi = '0; eExc = 1'b0; eRdy = 1'b0; eBusy = 1'b0;
      left = 0;
    end else begin
      eRdy = 1'b0;
      if (bus.ctrl_MULT || bus.ctrl_DIV) begin
        mA = bus.data_operandA;
        mB = bus.data_operandB;
        if (bus.ctrl_MULT) begin
          mP      = longint'(mA) * longint'(mB);
          pResult = mP[31:0];
          pHi     = mP[63:32];
          pExc    = (mP < -(64'sd1 <<< 31)) || (mP >= (64'sd1 <<< 31));
          lat     = 33;
        end else if (mB == 0) begin
          pResult = '0; pHi = '0; pExc = 1'b1; lat = 1;
        end else if (bus.data_operandA == INT_MIN && bus.data_operandB == 32'hFFFF_FFFF) begin
          pResult = INT_MIN; pHi = '0; pExc = 1'b1; lat = 33;
        end else begin
          mP      = longint'(mA) / longint'(mB);
          pResult = mP[31:0]; pHi = '0; pExc = 1'b0; lat = 33;
        end
        if (lat == 1) begin
          eResult = pResult; eHi = pHi; eExc = pExc; eRdy = 1'b1; eBusy = 1'b0;
          left = 0;
        end else begin
          left  = lat - 1;
          eBusy = 1'b1;
        end
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          eResult = pResult; eHi = pHi; eExc = pExc; eRdy = 1'b1; eBusy = 1'b0;
        end
      end else begin
        eBusy = 1'b0;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clock) begin
    if (checkEn) begin
      check("cyc rdy",    64'(bus.data_resultRDY), 64'(eRdy));
      check("cyc busy",   64'(bus.busy),           64'(eBusy));
      check("cyc result", 64'(bus.data_result),    64'(eResult));
      check("cyc hi",     64'(bus.data_hi),        64'(eHi));
      check("cyc exc",    64'(bus.data_exception), 64'(eExc));
    end
  end

  // Drive a one-cycle start pulse; returns one step after the sampling edge.
  task automatic applyStimulus(input logic doMult, input logic doDiv,
                               input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = doMult;
    bus.ctrl_DIV      = doDiv;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Wait (bounded) for the ready pulse and check latency and results.
  task automatic checkOutput(input string name, input int expLat,
                             input logic [31:0] expRes, input logic [31:0] expHi,
                             input logic expExc);
    int cyc = 0;
    while (!bus.data_resultRDY && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check({name, " latency"}, 64'(cyc + 1), 64'(expLat));
    check({name, " result"},  64'(bus.data_result),    64'(expRes));
    check({name, " hi"},      64'(bus.data_hi),        64'(expHi));
    check({name, " exc"},     64'(bus.data_exception), 64'(expExc));
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return INT_MIN;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'(int'($urandom_range(0, 200)) - 100);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rdyCount;
    int gap;
    int kind;

    reset_n           = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    repeat (3) @(posedge clock);
    #1;
    check("reset result", 64'(bus.data_result),    64'h0);
    check("reset hi",     64'(bus.data_hi),        64'h0);
    check("reset exc",    64'(bus.data_exception), 64'h0);
    check("reset rdy",    64'(bus.data_resultRDY), 64'h0);
    check("reset busy",   64'(bus.busy),           64'h0);
    #2;
    reset_n = 1'b1;
    checkEn = 1'b1;

    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    checkOutput("mult 7x-3", 33, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);

    applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    checkOutput("mult 2^16x2^16", 33, 32'h0, 32'h1, 1'b1);

    applyStimulus(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1);
    checkOutput("mult max x1", 33, 32'h7FFF_FFFF, 32'h0, 1'b0);

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    checkOutput("div -100/7", 33, 32'hFFFF_FFF2, 32'h0, 1'b0);

    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0);
    checkOutput("div 5/0", 1, 32'h0, 32'h0, 1'b1);

    applyStimulus(1'b0, 1'b1, INT_MIN, 32'hFFFF_FFFF);
    checkOutput("div min/-1", 33, INT_MIN, 32'h0, 1'b1);

    // Abort: a multiply restarts the unit while a divide is in flight.
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
    checkOutput("abort mult 3x4", 33, 32'd12, 32'h0, 1'b0);

    applyStimulus(1'b1, 1'b1, 32'd6, 32'd2);
    checkOutput("both starts", 33, 32'd12, 32'h0, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd9);
    repeat (13) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset result", 64'(bus.data_result),    64'h0);
    check("midreset hi",     64'(bus.data_hi),        64'h0);
    check("midreset exc",    64'(bus.data_exception), 64'h0);
    check("midreset rdy",    64'(bus.data_resultRDY), 64'h0);
    check("midreset busy",   64'(bus.busy),           64'h0);
    #4;
    reset_n  = 1'b1;
    rdyCount = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) rdyCount++;
    end
    check("no rdy after reset", 64'(rdyCount), 64'h0);

    applyStimulus(1'b1, 1'b0, 32'd2, 32'd3);
    checkOutput("mult 2x3", 33, 32'd6, 32'h0, 1'b0);

    // Randomized operations, with occasional aborts and simultaneous starts.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(1, 3);
      applyStimulus(kind[0], kind[1], pickOperand(), pickOperand());
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 25) : $urandom_range(33, 38);
      repeat (gap) @(posedge clock);
    end

    repeat (40) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
